regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single regfile write port (wen/waddr/wdata) between two writeback sources.
- Source A: single-cycle execute writeback, fixed priority, no backpressure.
- Source B: long-latency unit (load/mul), valid/ready handshake, buffered in a small FIFO.
- Sits between the pipeline writeback stage and the regfile. Also provides a read-after-write hazard flag for decode and a starvation-guard stall to the pipeline.

Parameters:
- DEPTH, 2, number of B FIFO entries; power of 2, minimum 2.
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may lose to A before stall_a is raised; range 1..15.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  A write request this cycle.
- a_waddr  in  5  A destination register.
- a_wdata  in  32  A write data.
- b_valid  in  1  B write request.
- b_ready  out  1  FIFO can accept a B entry.
- b_waddr  in  5  B destination register.
- b_wdata  in  32  B write data.
- raddr1  in  5  decode read address 1, hazard query.
- raddr2  in  5  decode read address 2, hazard query.
- hazard  out  1  raddr1 or raddr2 (nonzero) matches any pending B write.
- stall_a  out  1  pipeline must hold A this cycle; a_valid is ignored while high.
- wen  out  1  regfile write enable, registered.
- waddr  out  5  regfile write address, registered.
- wdata  out  32  regfile write data, registered.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: one clock clk; reset_n asserted low clears state immediately.
- On reset: FIFO empty, starve counter 0, stall_a=0, wen=0, waddr=0, wdata=0, b_ready=1, hazard=0.
- Write suppression: a request with waddr==0 is never written. A to x0 is treated as a_valid=0. B to x0 completes its handshake but is not enqueued.
- B handshake: transfer occurs when b_valid && b_ready. b_ready = !full, decoded from the FIFO count only, with no combinational path from b_valid.
- Grant is evaluated each cycle:
  - A is eligible when a_valid && !stall_a && a_waddr!=0.
  - If A is eligible, A is granted.
  - Else, if the FIFO is non-empty, the FIFO head is granted and popped.
  - Else, nothing is granted.
- Output register: the granted request is loaded into wen/waddr/wdata at the next clk edge. With no grant, wen=0 and waddr/wdata hold their values. Latency is 1 cycle for A and at least 2 cycles for B (enqueue, then grant).
- Empty-FIFO bypass: none. B always passes through the FIFO.
- Simultaneous push and pop in the same cycle is allowed when not full. Count is unchanged; pointers wrap modulo DEPTH.
- Starvation guard:
  - The counter increments on each cycle where the FIFO is non-empty and A is granted. It clears on any cycle where the head is granted or the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, stall_a is driven to 1 for exactly one following cycle (registered) and the counter clears.
  - During that cycle the head is granted unconditionally.
- hazard is combinational. It is set when a nonzero raddr1 or raddr2 equals the waddr of any valid FIFO entry, or equals waddr while wen=1.
- Commit order equals grant order. If A and B target the same register, whichever is granted later overwrites the earlier write; the pipeline owns ordering.
- reset_n asserted mid-operation discards buffered entries. No write is issued after reset release until a new request arrives.

Test Plan:
- Reset with FIFO holding 2 entries -> wen=0, b_ready=1, hazard=0 immediately, asynchronously, before the next clk edge.
- A only: a_valid=1, a_waddr=5, a_wdata=0xDEADBEEF -> next cycle wen=1, waddr=5, wdata=0xDEADBEEF; next cycle with a_valid=0 -> wen=0.
- B fill: b_valid=1 for 3 cycles with a_valid=1 continuously (rd=3,4,6) -> b_ready=0 after 2 accepts. The third request is held until a FIFO slot frees; entries drain in order 3,4,6.
- Starvation, STARVE_LIMIT=4: FIFO holds rd=7 and a_valid=1 continuously -> after 4 A grants, stall_a=1 for 1 cycle; next write is waddr=7. A resumes the following cycle.
- x0 filter: a_waddr=0 with a_valid=1 alongside b_waddr=0 with b_valid=1 -> no wen ever; b_ready remains 1; FIFO count remains 0.
- Hazard: FIFO holds rd=9, raddr1=9 -> hazard=1. raddr1=0 with a pending x0 request -> hazard=0. Once the rd=9 write retires (wen drops) -> hazard=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between a fixed-priority single-cycle source (A)
// and a FIFO-buffered long-latency source (B), with a RAW hazard flag and a starvation guard.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_valid,
  input  logic [4:0]  a_waddr,
  input  logic [31:0] a_wdata,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_waddr,
  input  logic [31:0] b_wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic        hazard,
  output logic        stall_a,
  output logic        wen,
  output logic [4:0]  waddr,
  output logic [31:0] wdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a B transfer happens on any cycle where b_valid && b_ready.
  // b_ready depends only on the FIFO count, never on b_valid.

  logic [4:0]       fifo_addr [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] fifo_vld;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [3:0]       starve_cnt;

  logic full;
  logic empty;
  logic push;
  logic grant_a;
  logic grant_b;
  logic starve_hit;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign b_ready = !full;

  // Writes to x0 complete the handshake but are dropped here.
  assign push    = b_valid && !full && (b_waddr != 5'd0);
  assign grant_a = a_valid && !stall_a && (a_waddr != 5'd0);
  assign grant_b = !grant_a && !empty;

  assign starve_hit = grant_a && !empty && (starve_cnt == 4'(STARVE_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= b_waddr;
      fifo_data[wr_ptr] <= b_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fifo_vld <= '0;
    end else begin
      if (grant_b) begin
        rd_ptr           <= rd_ptr + AW'(1);
        fifo_vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr           <= wr_ptr + AW'(1);
        fifo_vld[wr_ptr] <= 1'b1;
      end
      count <= count + CW'(push) - CW'(grant_b);
    end
  end

  // stall_a is the registered form of reaching the limit; the stall cycle then
  // grants the head, which clears the counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      stall_a    <= 1'b0;
    end else begin
      stall_a <= starve_hit;
      if (grant_a && !empty && !starve_hit) begin
        starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (grant_a) begin
      wen   <= 1'b1;
      waddr <= a_waddr;
      wdata <= a_wdata;
    end else if (grant_b) begin
      wen   <= 1'b1;
      waddr <= fifo_addr[rd_ptr];
      wdata <= fifo_data[rd_ptr];
    end else begin
      wen   <= 1'b0;
    end
  end

  function automatic logic addr_hit(input logic [4:0] a);
    return ((raddr1 != 5'd0) && (raddr1 == a)) || ((raddr2 != 5'd0) && (raddr2 == a));
  endfunction

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i] && addr_hit(fifo_addr[i])) hazard = 1'b1;
    end
    if (wen && addr_hit(waddr)) hazard = 1'b1;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic, checked
// against a queue-level model with a scoreboard of expected regfile writes.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        hazard;
  logic        stall_a;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .raddr1(raddr1), .raddr2(raddr2), .hazard(hazard), .stall_a(stall_a),
    .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Scoreboard entry: {due_cycle[15:0], addr[4:0], data[31:0]}
  logic [52:0] exp_q[$];

  // Reference model: pending B writes in arrival order, plus guard/output state.
  logic [36:0] mq[$];
  logic        m_stall = 1'b0;
  int          m_starve = 0;
  logic        m_wen = 1'b0;
  logic [4:0]  m_waddr = 5'd0;
  int          stall_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_hazard(input logic [4:0] r1, input logic [4:0] r2);
    logic h = 1'b0;
    for (int i = 0; i < mq.size(); i++) begin
      if ((r1 != 0 && r1 == mq[i][36:32]) || (r2 != 0 && r2 == mq[i][36:32])) h = 1'b1;
    end
    if (m_wen && ((r1 != 0 && r1 == m_waddr) || (r2 != 0 && r2 == m_waddr))) h = 1'b1;
    return h;
  endfunction

  // One cycle: apply inputs at negedge, check flags, advance the model.
  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic [4:0] r1, input logic [4:0] r2, output logic acc);
    int          sz;
    logic        rdy;
    logic        gv;
    logic [4:0]  ga;
    logic [31:0] gd;
    logic [36:0] head;
    @(negedge clk);
    cyc++;
    a_valid = av; a_waddr = aa; a_wdata = ad;
    b_valid = bv; b_waddr = ba; b_wdata = bd;
    raddr1 = r1; raddr2 = r2;
    #1;
    sz  = mq.size();
    rdy = (sz < DEPTH);
    chk("b_ready", b_ready, rdy);
    chk("stall_a", stall_a, m_stall);
    chk("hazard", hazard, model_hazard(r1, r2));
    if (m_stall) stall_seen++;
    gv = 1'b0; ga = '0; gd = '0;
    if (av && !m_stall && aa != 0) begin
      gv = 1'b1; ga = aa; gd = ad;
      m_starve = (sz > 0) ? m_starve + 1 : 0;
    end else if (sz > 0) begin
      head = mq.pop_front();
      gv = 1'b1; ga = head[36:32]; gd = head[31:0];
      m_starve = 0;
    end else begin
      m_starve = 0;
    end
    if (bv && rdy && ba != 0) mq.push_back({ba, bd});
    m_stall = (m_starve == LIMIT);
    if (m_stall) m_starve = 0;
    if (gv) begin
      exp_q.push_back({16'(cyc + 1), ga, gd});
      m_waddr = ga;
    end
    m_wen = gv;
    acc = bv && rdy;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, acc);
  endtask

  // Monitor: every regfile write must match the oldest due expected write.
  initial begin
    logic [52:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (wen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", {27'd0, waddr}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("write_cycle", 32'(cyc), 32'(e[52:37]));
          chk("write_addr", {27'd0, waddr}, {27'd0, e[36:32]});
          chk("write_data", wdata, e[31:0]);
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][52:37]) <= cyc) begin
        chk("missing_write_wen", {31'd0, wen}, 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_reset(input logic [4:0] r1);
    @(negedge clk);
    cyc++;
    a_valid = 0; b_valid = 0; raddr1 = r1; raddr2 = 0;
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_wen", {31'd0, wen}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd1);
    chk("rst_hazard", {31'd0, hazard}, 32'd0);
    chk("rst_stall_a", {31'd0, stall_a}, 32'd0);
    mq.delete(); exp_q.delete();
    m_stall = 0; m_starve = 0; m_wen = 0; m_waddr = 0;
    @(negedge clk);
    cyc++;
    #3;
    chk("rst_hold_wen", {31'd0, wen}, 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    logic        acc;
    int          k;
    int          s0;
    logic [4:0]  bseq [3];
    logic        pb;
    logic [4:0]  pba;
    logic [31:0] pbd;

    reset_n = 1'b0;
    a_valid = 0; a_waddr = 0; a_wdata = 0;
    b_valid = 0; b_waddr = 0; b_wdata = 0;
    raddr1 = 0; raddr2 = 0;
    #1;
    chk("init_wen", {31'd0, wen}, 32'd0);
    chk("init_waddr", {27'd0, waddr}, 32'd0);
    chk("init_wdata", wdata, 32'd0);
    chk("init_b_ready", {31'd0, b_ready}, 32'd1);
    chk("init_hazard", {31'd0, hazard}, 32'd0);
    @(negedge clk);
    #3 reset_n = 1'b1;

    // A only
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, acc);
    drive(0, 0, 0, 0, 0, 0, 0, 0, acc);
    chk("a_only_wen", {31'd0, wen}, 32'd1);
    chk("a_only_waddr", {27'd0, waddr}, 32'd5);
    chk("a_only_wdata", wdata, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 0, 0, 0, acc);
    chk("a_only_wen_drop", {31'd0, wen}, 32'd0);

    // B fill behind continuous A traffic; third request held until a slot frees
    bseq[0] = 3; bseq[1] = 4; bseq[2] = 6;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 5'(10 + (i % 4)), 32'(i), k < 3, (k < 3) ? bseq[k] : 5'd0,
            32'hB000 + 32'(k), 0, 0, acc);
      if (acc && k < 3) k++;
    end
    chk("b_fill_accepted", 32'(k), 32'd3);
    idle(4);

    // Starvation guard
    drive(0, 0, 0, 1, 7, 32'h7777, 0, 0, acc);
    s0 = stall_seen;
    for (int i = 0; i < 6; i++) drive(1, 12, 32'hA000 + 32'(i), 0, 0, 0, 0, 0, acc);
    chk("starve_stall_count", 32'(stall_seen - s0), 32'd1);
    idle(3);

    // x0 filter
    for (int i = 0; i < 3; i++) drive(1, 0, 32'h1111, 1, 0, 32'h2222, 0, 0, acc);
    idle(2);

    // Hazard against a pending B write, then through its retirement
    drive(0, 0, 0, 1, 9, 32'h9999, 0, 0, acc);
    drive(1, 0, 32'h1, 1, 0, 32'h2, 9, 0, acc);
    drive(0, 0, 0, 0, 0, 0, 0, 0, acc);
    drive(0, 0, 0, 0, 0, 0, 9, 0, acc);
    idle(2);

    // Reset while the FIFO holds two entries
    drive(1, 13, 32'h1313, 1, 20, 32'h2020, 0, 0, acc);
    drive(1, 14, 32'h1414, 1, 21, 32'h2121, 0, 0, acc);
    do_reset(20);
    idle(3);

    // Random traffic; B requests stay asserted until accepted
    pb = 0; pba = 0; pbd = 0;
    for (int i = 0; i < 600; i++) begin
      if (!pb && $urandom_range(0, 1) == 1) begin
        pb = 1; pba = 5'($urandom_range(0, 7)); pbd = $urandom;
      end
      drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
            pb, pba, pbd, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
      if (acc) pb = 0;
    end
    idle(6);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
